spongent_perm_engine: RTL and testbench

- Self-sequenced SPONGENT sponge engine with an internal FSM: absorb, permute, squeeze. Replaces the externally controlled datapath and its separate controller.
- Generalised over state size, rate, round count, hash length and rounds per cycle (UNROLL).
- Valid/ready streams on both sides. Sits between the message/MAC front-end and hash consumers in the crypto unit.

---
 rtl/spongent_perm_engine.sv | 203 ++++++++++++++++++++
 tb/tb_spongent_perm_engine.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spongent_perm_engine.sv
// Self-sequenced SPONGENT sponge engine: absorb, permute, squeeze over valid/ready streams.
// Optional feature: define SPONGENT_PERF_CNT_EN to count completed permutations on perm_count.
module spongent_perm_engine #(
  parameter int                   STATE_SIZE  = 136,
  parameter int                   RATE        = 8,
  parameter int unsigned          LFSR_POLY   = 8'b11000001,
  parameter int                   LFSR_SIZE   = 7,
  parameter logic [LFSR_SIZE-1:0] LFSR_INIT   = 7'b1111010,
  parameter int                   NUM_ROUNDS  = 70,
  parameter int                   UNROLL      = 1,
  parameter int                   HASH_BLOCKS = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            soft_clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RATE-1:0] in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [RATE-1:0] out_data,
  output logic            out_last,
  output logic            busy,
  output logic [31:0]     perm_count
);

  localparam int NUM_SBOXES  = (STATE_SIZE + 3) / 4;
  localparam int PAD_SIZE    = NUM_SBOXES * 4;
  localparam int PERM_CYCLES = NUM_ROUNDS / UNROLL;
  localparam int RC_W        = (PERM_CYCLES > 1) ? $clog2(PERM_CYCLES) : 1;
  localparam int BC_W        = (HASH_BLOCKS > 1) ? $clog2(HASH_BLOCKS) : 1;
  // Feedback taps: polynomial terms above x^0, so x^LFSR_SIZE lines up with the MSB.
  localparam logic [LFSR_SIZE-1:0] LFSR_TAPS = LFSR_SIZE'(LFSR_POLY >> 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ABSORB  = 2'd1;
  localparam logic [1:0] PERM    = 2'd2;
  localparam logic [1:0] SQUEEZE = 2'd3;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] r;
    case (x)
      4'h0: r = 4'hE;  4'h1: r = 4'hD;  4'h2: r = 4'hB;  4'h3: r = 4'h0;
      4'h4: r = 4'h2;  4'h5: r = 4'h1;  4'h6: r = 4'h4;  4'h7: r = 4'hF;
      4'h8: r = 4'h7;  4'h9: r = 4'hA;  4'hA: r = 4'h8;  4'hB: r = 4'h5;
      4'hC: r = 4'h9;  4'hD: r = 4'hC;  4'hE: r = 4'h3;  default: r = 4'h6;
    endcase
    return r;
  endfunction

  function automatic int p_pos(input int j);
    if (j == STATE_SIZE - 1) return j;
    return (j * (STATE_SIZE / 4)) % (STATE_SIZE - 1);
  endfunction

  function automatic logic [LFSR_SIZE-1:0] lfsr_step(input logic [LFSR_SIZE-1:0] v);
    return {v[LFSR_SIZE-2:0], ^(v & LFSR_TAPS)};
  endfunction

  logic [1:0]            fsm_reg,   fsm_next;
  logic [STATE_SIZE-1:0] state_reg, state_next;
  logic [LFSR_SIZE-1:0]  lfsr_reg,  lfsr_next;
  logic [RC_W-1:0]       round_reg, round_next;
  logic [BC_W-1:0]       block_reg, block_next;
  logic                  last_reg,  last_next;
  logic                  perm_final;

  // Round pipeline: UNROLL rounds chained combinationally, LFSR stepped alongside.
  logic [STATE_SIZE-1:0] rnd_state [0:UNROLL];
  logic [LFSR_SIZE-1:0]  rnd_lfsr  [0:UNROLL];

  assign rnd_state[0] = state_reg;
  assign rnd_lfsr[0]  = lfsr_reg;

  for (genvar gi = 0; gi < UNROLL; gi++) begin : g_round
    logic [STATE_SIZE-1:0] with_rc;
    logic [PAD_SIZE-1:0]   sbox_in;
    logic [PAD_SIZE-1:0]   sbox_out;
    logic [STATE_SIZE-1:0] perm_out;

    // Counter goes into the low bits, its bit-reversal into the top bits.
    always_comb begin
      with_rc = rnd_state[gi];
      for (int k = 0; k < LFSR_SIZE; k++) begin
        with_rc[k]              = with_rc[k] ^ rnd_lfsr[gi][k];
        with_rc[STATE_SIZE-1-k] = with_rc[STATE_SIZE-1-k] ^ rnd_lfsr[gi][k];
      end
    end

    assign sbox_in = PAD_SIZE'(with_rc);

    for (genvar gj = 0; gj < NUM_SBOXES; gj++) begin : g_sbox
      assign sbox_out[4*gj +: 4] = sbox(sbox_in[4*gj +: 4]);
    end

    for (genvar gk = 0; gk < STATE_SIZE; gk++) begin : g_player
      assign perm_out[p_pos(gk)] = sbox_out[gk];
    end

    assign rnd_state[gi+1] = perm_out;
    assign rnd_lfsr[gi+1]  = lfsr_step(rnd_lfsr[gi]);
  end

  assign perm_final = (round_reg == RC_W'(PERM_CYCLES - 1));

  always_comb begin
    fsm_next   = fsm_reg;
    state_next = state_reg;
    lfsr_next  = lfsr_reg;
    round_next = round_reg;
    block_next = block_reg;
    last_next  = last_reg;
    if (soft_clear) begin
      fsm_next   = IDLE;
      state_next = '0;
      lfsr_next  = '0;
      round_next = '0;
      block_next = '0;
      last_next  = 1'b0;
    end else begin
      case (fsm_reg)
        IDLE, ABSORB: begin
          if (in_valid) begin
            state_next[RATE-1:0] = state_reg[RATE-1:0] ^ in_data;
            last_next            = in_last;
            round_next           = '0;
            lfsr_next            = LFSR_INIT;
            fsm_next             = PERM;
          end
        end
        PERM: begin
          state_next = rnd_state[UNROLL];
          lfsr_next  = rnd_lfsr[UNROLL];
          round_next = round_reg + 1'b1;
          if (perm_final) begin
            round_next = '0;
            fsm_next   = last_reg ? SQUEEZE : ABSORB;
          end
        end
        default: begin
          if (out_ready) begin
            if (block_reg == BC_W'(HASH_BLOCKS - 1)) begin
              state_next = '0;
              block_next = '0;
              last_next  = 1'b0;
              fsm_next   = IDLE;
            end else begin
              block_next = block_reg + 1'b1;
              round_next = '0;
              lfsr_next  = LFSR_INIT;
              fsm_next   = PERM;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg   <= IDLE;
      state_reg <= '0;
      lfsr_reg  <= '0;
      round_reg <= '0;
      block_reg <= '0;
      last_reg  <= 1'b0;
    end else begin
      fsm_reg   <= fsm_next;
      state_reg <= state_next;
      lfsr_reg  <= lfsr_next;
      round_reg <= round_next;
      block_reg <= block_next;
      last_reg  <= last_next;
    end
  end

  assign in_ready  = (fsm_reg == IDLE) || (fsm_reg == ABSORB);
  assign out_valid = (fsm_reg == SQUEEZE);
  assign out_data  = state_reg[RATE-1:0];
  assign out_last  = out_valid && (block_reg == BC_W'(HASH_BLOCKS - 1));
  assign busy      = (fsm_reg != IDLE);

`ifdef SPONGENT_PERF_CNT_EN
  logic [31:0] perm_count_reg;
  logic        perm_done;

  // An aborted permutation never completes, so soft_clear suppresses the count.
  assign perm_done = (fsm_reg == PERM) && perm_final && !soft_clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      perm_count_reg <= '0;
    else if (perm_done)
      perm_count_reg <= perm_count_reg + 32'd1;
  end

  assign perm_count = perm_count_reg;
`else
  assign perm_count = 32'h0;
`endif

endmodule

// File: tb/tb_spongent_perm_engine.sv
// Self-checking bench for spongent_perm_engine: cycle timing, handshakes and digests
// against a bit-level sponge model built directly from the SPONGENT round definition.
`timescale 1ns/1ps
module tb_spongent_perm_engine;
  localparam int SS  = 136;
  localparam int NR  = 70;
  localparam int UN  = 1;
  localparam int HB  = 16;
  localparam int LAT = NR / UN;

  logic       clk = 1'b0, rst_n = 1'b0, soft_clear = 1'b0;
  logic       in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, out_valid, out_last, busy;
  logic [7:0] out_data;
  logic [31:0] perm_count;

  spongent_perm_engine #(.UNROLL(UN)) dut (
    .clk(clk), .rst_n(rst_n), .soft_clear(soft_clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .perm_count(perm_count)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int checks = 0, passed = 0;
  int unstable = 0, exp_perms = 0;
  int acc [4];
  int vcyc [HB], hcyc [HB];
  logic [7:0] got [HB];
  logic       got_last [HB];
  bit [7:0]   exp_dig [HB];
  bit [7:0]   msg_q [$];
  bit [3:0]   sbox_tab [16] = '{4'hE, 4'hD, 4'hB, 4'h0, 4'h2, 4'h1, 4'h4, 4'hF,
                                4'h7, 4'hA, 4'h8, 4'h5, 4'h9, 4'hC, 4'h3, 4'h6};

  // SPONGENT-136 permutation: counter x^7+x^6+1 from 0x7A, 70 rounds.
  function automatic bit [SS-1:0] ref_perm(input bit [SS-1:0] s_in);
    bit [SS-1:0] s, t;
    int unsigned ctr;
    s = s_in;
    ctr = 32'h7A;
    for (int r = 0; r < NR; r++) begin
      for (int i = 0; i < 7; i++) begin
        s[i]        ^= ctr[i];
        s[SS-1-i]   ^= ctr[i];
      end
      for (int n = 0; n < SS/4; n++) s[4*n +: 4] = sbox_tab[s[4*n +: 4]];
      t = '0;
      for (int j = 0; j < SS; j++) t[(j == SS-1) ? j : (j * (SS/4)) % (SS-1)] = s[j];
      s = t;
      ctr = ((ctr << 1) | (((ctr >> 6) ^ (ctr >> 5)) & 32'd1)) & 32'h7F;
    end
    return s;
  endfunction

  task automatic model_hash();
    bit [SS-1:0] s;
    s = '0;
    foreach (msg_q[i]) begin
      s[7:0] ^= msg_q[i];
      s = ref_perm(s);
    end
    for (int b = 0; b < HB; b++) begin
      exp_dig[b] = s[7:0];
      if (b < HB - 1) s = ref_perm(s);
    end
  endtask

  function automatic logic [31:0] exp_pc();
`ifdef SPONGENT_PERF_CNT_EN
    return exp_perms;
`else
    return 32'h0;
`endif
  endfunction

  task automatic send_block(input logic [7:0] d, input bit last, input bit hold, output int a);
    int w;
    w = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    while (in_ready !== 1'b1 && w < 500) begin @(negedge clk); w++; end
    if (in_ready !== 1'b1) begin
      checks++;
      $display("FAIL in_ready_timeout: in_ready=%b required 1 within 500 cycles", in_ready);
    end
    a = cycle + 1;
    @(negedge clk);
    if (!hold) begin in_valid = 1'b0; in_last = 1'b0; end
  endtask

  task automatic send_msg(input bit hold);
    for (int i = 0; i < msg_q.size(); i++)
      send_block(msg_q[i], i == msg_q.size() - 1, hold && (i != msg_q.size() - 1), acc[i]);
  endtask

  task automatic wait_valid(output bit ok);
    int w;
    w = 0;
    while (out_valid !== 1'b1 && w < 500) begin @(negedge clk); w++; end
    ok = (out_valid === 1'b1);
    if (!ok) begin
      checks++;
      $display("FAIL out_valid_timeout: out_valid=%b required 1 within 500 cycles", out_valid);
    end
  endtask

  task automatic recv_hash(input int nblk, input int stall_blk, input int stall_len, input bit rnd);
    bit ok;
    int sl;
    foreach (got[i]) begin got[i] = 'x; got_last[i] = 1'bx; end
    for (int b = 0; b < nblk; b++) begin
      wait_valid(ok);
      if (!ok) return;
      vcyc[b] = cycle; got[b] = out_data; got_last[b] = out_last;
      sl = (b == stall_blk) ? stall_len : 0;
      if (rnd && $urandom_range(0, 2) == 0) sl = $urandom_range(1, 6);
      out_ready = (sl == 0);
      for (int k = 0; k < sl; k++) begin
        @(negedge clk);
        if (out_valid !== 1'b1 || out_data !== got[b] || out_last !== got_last[b] || busy !== 1'b1)
          unstable++;
        if (k == sl - 1) out_ready = 1'b1;
      end
      hcyc[b] = cycle + 1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0)
      $display("FAIL reset_held: rdy/busy/ov/ol=%b%b%b%b required 1000", in_ready, busy, out_valid, out_last);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00)
      $display("FAIL reset_release: rdy/busy/ov=%b%b%b data=%h required 100 00", in_ready, busy, out_valid, out_data);
    else passed++;
    checks++; if (perm_count !== 32'h0)
      $display("FAIL reset_perm_count: got %0d required 0", perm_count);
    else passed++;
    $display("reset: done");
  endtask

  task automatic test_reset_mid_perm();
    int a;
    send_block(8'h80, 1'b1, 1'b0, a);
    repeat (29) @(negedge clk);
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL mid_perm_busy: busy=%b in_ready=%b required 1 0", busy, in_ready);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL async_reset: rdy/busy/ov=%b%b%b required 100", in_ready, busy, out_valid);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    exp_perms = 0;
    msg_q = '{8'h80};
    model_hash();
    send_msg(1'b0);
    recv_hash(HB, -1, 0, 1'b0);
    exp_perms += 1 + HB - 1;
    for (int b = 0; b < HB; b++) begin
      checks++; if (got[b] !== exp_dig[b])
        $display("FAIL post_reset_digest[%0d]: got %h required %h", b, got[b], exp_dig[b]);
      else passed++;
    end
    $display("reset_mid_perm: digest block0=%h", got[0]);
  endtask

  task automatic test_single_block();
    msg_q = '{8'h80};
    model_hash();
    send_msg(1'b0);
    recv_hash(HB, -1, 0, 1'b0);
    exp_perms += HB;
    checks++; if (vcyc[0] - acc[0] !== LAT)
      $display("FAIL accept_latency: got %0d required %0d", vcyc[0] - acc[0], LAT);
    else passed++;
    for (int b = 1; b < HB; b++) begin
      checks++; if (hcyc[b] - hcyc[b-1] !== LAT + 1)
        $display("FAIL squeeze_interval[%0d]: got %0d required %0d", b, hcyc[b] - hcyc[b-1], LAT + 1);
      else passed++;
    end
    for (int b = 0; b < HB; b++) begin
      checks++; if (got_last[b] !== (b == HB - 1))
        $display("FAIL out_last[%0d]: got %b required %b", b, got_last[b], b == HB - 1);
      else passed++;
      checks++; if (got[b] !== exp_dig[b])
        $display("FAIL single_digest[%0d]: got %h required %h", b, got[b], exp_dig[b]);
      else passed++;
    end
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL idle_after_hash: busy/ov/rdy=%b%b%b required 001", busy, out_valid, in_ready);
    else passed++;
    $display("single_block: latency=%0d digest block0=%h", vcyc[0] - acc[0], got[0]);
  endtask

  task automatic test_back_to_back();
    msg_q = '{8'h61, 8'h62, 8'h63};
    model_hash();
    send_msg(1'b1);
    recv_hash(HB, -1, 0, 1'b0);
    exp_perms += 3 + HB - 1;
    for (int i = 1; i < 3; i++) begin
      checks++; if (acc[i] - acc[i-1] !== LAT + 1)
        $display("FAIL absorb_interval[%0d]: got %0d required %0d", i, acc[i] - acc[i-1], LAT + 1);
      else passed++;
    end
    for (int b = 0; b < HB; b++) begin
      checks++; if (got[b] !== exp_dig[b])
        $display("FAIL abc_digest[%0d]: got %h required %h", b, got[b], exp_dig[b]);
      else passed++;
    end
    $display("back_to_back: abc digest block0=%h", got[0]);
  endtask

  task automatic test_backpressure();
    msg_q = '{8'h80};
    model_hash();
    unstable = 0;
    send_msg(1'b0);
    recv_hash(HB, 4, 20, 1'b0);
    exp_perms += HB;
    checks++; if (unstable !== 0)
      $display("FAIL stall_stability: got %0d unstable cycles required 0", unstable);
    else passed++;
    checks++; if (hcyc[4] - vcyc[4] !== 21)
      $display("FAIL stall_duration: got %0d required 21", hcyc[4] - vcyc[4]);
    else passed++;
    for (int b = 0; b < HB; b++) begin
      checks++; if (got[b] !== exp_dig[b])
        $display("FAIL stall_digest[%0d]: got %h required %h", b, got[b], exp_dig[b]);
      else passed++;
    end
    $display("backpressure: block4=%h held 20 cycles", got[4]);
  endtask

  task automatic test_soft_clear();
    bit ok;
    msg_q = '{8'h80};
    model_hash();
    send_msg(1'b0);
    recv_hash(2, -1, 0, 1'b0);
    wait_valid(ok);
    checks++; if (out_data !== exp_dig[2])
      $display("FAIL pre_clear_block: got %h required %h", out_data, exp_dig[2]);
    else passed++;
    soft_clear = 1'b1;
    @(negedge clk);
    soft_clear = 1'b0;
    exp_perms += 3;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL soft_clear_idle: ov/busy/rdy=%b%b%b required 001", out_valid, busy, in_ready);
    else passed++;
    checks++; if (perm_count !== exp_pc())
      $display("FAIL soft_clear_perm_count: got %0d required %0d", perm_count, exp_pc());
    else passed++;
    msg_q = '{8'h5A, 8'hC3};
    model_hash();
    send_msg(1'b0);
    recv_hash(HB, -1, 0, 1'b0);
    exp_perms += 2 + HB - 1;
    for (int b = 0; b < HB; b++) begin
      checks++; if (got[b] !== exp_dig[b])
        $display("FAIL post_clear_digest[%0d]: got %h required %h", b, got[b], exp_dig[b]);
      else passed++;
    end
    $display("soft_clear: perm_count=%0d", perm_count);
  endtask

  task automatic test_random();
    int len;
    for (int m = 0; m < 6; m++) begin
      len = $urandom_range(1, 4);
      msg_q = {};
      for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
      model_hash();
      unstable = 0;
      send_msg(bit'($urandom_range(0, 1)));
      recv_hash(HB, -1, 0, 1'b1);
      exp_perms += len + HB - 1;
      checks++; if (unstable !== 0)
        $display("FAIL rand_stability[%0d]: got %0d unstable cycles required 0", m, unstable);
      else passed++;
      for (int b = 0; b < HB; b++) begin
        checks++; if (got[b] !== exp_dig[b] || got_last[b] !== (b == HB - 1))
          $display("FAIL rand_digest[%0d][%0d]: got %h/%b required %h/%b", m, b, got[b], got_last[b],
                   exp_dig[b], b == HB - 1);
        else passed++;
      end
      $display("random msg %0d: %0d blocks, digest block0=%h", m, len, got[0]);
    end
  endtask

  task automatic test_perf_count();
    checks++; if (perm_count !== exp_pc())
      $display("FAIL final_perm_count: got %0d required %0d", perm_count, exp_pc());
    else passed++;
    $display("perf_count: perm_count=%0d", perm_count);
  endtask

  initial begin
    test_reset();
    test_reset_mid_perm();
    test_single_block();
    test_back_to_back();
    test_backpressure();
    test_soft_clear();
    test_random();
    test_perf_count();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
